// File: rtl/c_join_sync.sv
// N-input generalised C-element feeding a 4-phase join controller, with
// sticky protocol/timeout flags and a completed-handshake counter.
module c_join_sync #(
  parameter int N_IN           = 2,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN-1:0]   req_in,
  input  logic [N_IN-1:0]   en,
  output logic [N_IN-1:0]   ack_in,
  output logic              req_out,
  input  logic              ack_out,
  output logic              q,
  input  logic              clear_err,
  output logic              proto_err,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  hs_count
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, ACK, RTZ} state_t;

  state_t           state_q, state_d;
  logic             q_q, q_d;
  logic             req_out_q, req_out_d;
  logic [N_IN-1:0]  ack_in_q, ack_in_d;
  logic             proto_q, proto_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] hs_count_q, hs_count_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [N_IN-1:0]  en_lat_q, en_lat_d;
  logic [N_IN-1:0]  req_prev_q, req_prev_d;
  logic             ack_prev_q, ack_prev_d;

  logic [N_IN-1:0]  mask;
  logic             proto_set;
  logic             timeout_set;

  always_comb begin
    // C-element: a fully disabled mask can neither set nor clear q
    mask = (state_q == IDLE) ? en : en_lat_q;
    q_d  = q_q;
    if (mask != '0) begin
      if ((req_in & mask) == mask)    q_d = 1'b1;
      else if ((req_in & mask) == '0) q_d = 1'b0;
    end

    state_d    = state_q;
    en_lat_d   = en_lat_q;
    hs_count_d = hs_count_q;
    case (state_q)
      IDLE: if (q_q) begin
              state_d  = REQ;
              en_lat_d = en;
            end
      REQ:  if (ack_out) state_d = ACK;
      ACK:  if (!q_q)    state_d = RTZ;
      RTZ:  if (!ack_out) begin
              state_d    = IDLE;
              hs_count_d = hs_count_q + 1'b1;
            end
      default: state_d = IDLE;
    endcase

    req_out_d = (state_d == REQ) || (state_d == ACK);
    ack_in_d  = ((state_d == ACK) || (state_d == RTZ)) ? en_lat_d : '0;

    req_prev_d = req_in;
    ack_prev_d = ack_out;
    proto_set  = ((state_q == IDLE) && ack_out) ||
                 ((state_q == REQ)  && ((en_lat_q & req_prev_q & ~req_in) != '0)) ||
                 ((state_q == RTZ)  && ack_out && !ack_prev_q);
    proto_d    = proto_set | (proto_q & ~clear_err);

    // Flag fires only on the step onto T_MAX so clear_err sticks while saturated
    timer_d     = timer_q;
    timeout_set = 1'b0;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if ((TIMEOUT_CYCLES > 0) && (state_q != IDLE) && (timer_q != T_MAX)) begin
      timer_d     = timer_q + 1'b1;
      timeout_set = (timer_d == T_MAX);
    end
    timeout_d = timeout_set | (timeout_q & ~clear_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      q_q        <= 1'b0;
      req_out_q  <= 1'b0;
      ack_in_q   <= '0;
      proto_q    <= 1'b0;
      timeout_q  <= 1'b0;
      hs_count_q <= '0;
      timer_q    <= '0;
      en_lat_q   <= '1;
      req_prev_q <= '0;
      ack_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      req_out_q  <= req_out_d;
      ack_in_q   <= ack_in_d;
      proto_q    <= proto_d;
      timeout_q  <= timeout_d;
      hs_count_q <= hs_count_d;
      timer_q    <= timer_d;
      en_lat_q   <= en_lat_d;
      req_prev_q <= req_prev_d;
      ack_prev_q <= ack_prev_d;
    end
  end

  assign q           = q_q;
  assign req_out     = req_out_q;
  assign ack_in      = ack_in_q;
  assign proto_err   = proto_q;
  assign timeout_err = timeout_q;
  assign hs_count    = hs_count_q;

endmodule

// File: tb/tb_c_join_sync.sv
// Randomised join-controller bench: a producer/consumer pair drives handshakes,
// a scoreboard queue holds the expected ack mask and count per handshake.
module tb_c_join_sync;

  localparam int N  = 3;
  localparam int TO = 8;
  localparam int CW = 2;

  logic          clk, rst;
  logic [N-1:0]  req_in, en, ack_in;
  logic          req_out, ack_out, q, clear_err, proto_err, timeout_err;
  logic [CW-1:0] hs_count;

  c_join_sync #(.N_IN(N), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .en(en), .ack_in(ack_in),
    .req_out(req_out), .ack_out(ack_out), .q(q), .clear_err(clear_err),
    .proto_err(proto_err), .timeout_err(timeout_err), .hs_count(hs_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  mask;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          exp_q[$];
  logic [CW-1:0] exp_cnt;
  int            n_chk, n_pass;
  bit            auto_ack, junk_on;
  logic [N-1:0]  cur_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One cycle; disabled request lines carry random junk that must be ignored
  task automatic step();
    @(negedge clk);
    if (junk_on) req_in = (req_in & cur_m) | (3'($urandom) & ~cur_m);
  endtask

  task automatic push_exp(input logic [N-1:0] m);
    exp_t e;
    exp_cnt = exp_cnt + 1'b1;
    e.mask  = m;
    e.cnt   = exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic do_hs(input logic [N-1:0] m, input bit tog);
    logic [N-1:0] rem;
    int i, k;
    cur_m   = m;
    en      = m;
    req_in  = 3'($urandom) & ~m;
    junk_on = 1'b1;
    push_exp(m);
    step();
    rem = m;
    while (rem != '0) begin
      i = $urandom_range(0, N-1);
      if (!rem[i]) continue;
      rem[i] = 1'b0;
      if (rem == '0) chk("q_partial_rise", q, 0);
      req_in[i] = 1'b1;
      if (rem != '0) repeat ($urandom_range(0, 1)) step();
    end
    step(); chk("q_set", q, 1); chk("req_out_lat0", req_out, 0);
    step(); chk("req_out_lat1", req_out, 1);
    k = 0;
    while (ack_in == '0 && k < 40) begin step(); k++; end
    chk("ack_in_seen", ack_in, m);
    if (tog) begin
      en = 3'($urandom);
      step();
      chk("ack_in_hold_en", ack_in, m);
    end
    rem = m;
    while (rem != '0) begin
      i = $urandom_range(0, N-1);
      if (!rem[i]) continue;
      rem[i] = 1'b0;
      if (rem == '0) begin
        chk("q_partial_fall", q, 1);
        junk_on = 1'b0;
        req_in  = '0;
      end else begin
        req_in[i] = 1'b0;
        repeat ($urandom_range(0, 1)) step();
      end
    end
    step(); chk("q_clr", q, 0); chk("req_out_fall0", req_out, 1);
    step(); chk("req_out_fall1", req_out, 0);
    k = 0;
    while (ack_in != '0 && k < 40) begin step(); k++; end
    chk("ack_in_rtz", ack_in, 0);
    step();
  endtask

  // Consumer: follows req_out with a random delay of 0..3 cycles
  initial begin
    int d;
    d = 0;
    forever begin
      @(negedge clk);
      if (auto_ack && (req_out != ack_out)) begin
        if (d == 0) begin
          ack_out = req_out;
          d = $urandom_range(0, 3);
        end else d--;
      end
    end
  end

  // Monitor: ack mask on each rising ack_in, count on each hs_count change
  initial begin
    logic [N-1:0]  pa;
    logic [CW-1:0] ph;
    exp_t e;
    pa = '0; ph = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pa == '0 && ack_in != '0) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL sb_ack_unexpected: got %0h expected none", ack_in);
          end else chk("sb_ack_mask", ack_in, exp_q[0].mask);
        end
        if (hs_count != ph) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL sb_cnt_unexpected: got %0h expected none", hs_count);
          end else begin
            e = exp_q.pop_front();
            chk("sb_hs_count", hs_count, e.cnt);
          end
        end
      end
      pa = ack_in;
      ph = hs_count;
    end
  end

  initial begin
    int k;
    n_chk = 0; n_pass = 0; exp_cnt = '0;
    auto_ack = 1'b0; junk_on = 1'b0; cur_m = '1;
    rst = 1'b1; en = '1; req_in = '0; ack_out = 1'b0; clear_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_q", q, 0); chk("rst_req_out", req_out, 0); chk("rst_ack_in", ack_in, 0);
    chk("rst_proto", proto_err, 0); chk("rst_timeout", timeout_err, 0);
    chk("rst_count", hs_count, 0);
    rst = 1'b0;
    @(negedge clk);

    auto_ack = 1'b1;
    do_hs(3'b111, 1'b0);
    do_hs(3'b101, 1'b1);

    // ack_out asserted while idle
    auto_ack = 1'b0;
    ack_out = 1'b1; @(negedge clk);
    chk("proto_idle_ack", proto_err, 1);
    ack_out = 1'b0; clear_err = 1'b1; @(negedge clk);
    clear_err = 1'b0;
    chk("proto_clear0", proto_err, 0);

    // Stall in REQ: timeout, then request drops
    en = 3'b111; push_exp(3'b111); req_in = 3'b111;
    k = 0;
    while (!req_out && k < 40) begin @(negedge clk); k++; end
    chk("req_out_manual", req_out, 1);
    repeat (7) @(negedge clk);
    chk("timeout_early", timeout_err, 0);
    @(negedge clk);
    chk("timeout_set", timeout_err, 1);
    req_in = 3'b110; @(negedge clk);
    chk("proto_req_drop", proto_err, 1);
    req_in = 3'b100; clear_err = 1'b1; @(negedge clk);
    clear_err = 1'b0;
    chk("proto_set_wins", proto_err, 1);
    clear_err = 1'b1; @(negedge clk);
    clear_err = 1'b0;
    chk("proto_clear1", proto_err, 0);
    chk("timeout_clear", timeout_err, 0);
    chk("q_hold_req", q, 1);
    ack_out = 1'b1; @(negedge clk);
    chk("ack_in_manual", ack_in, 3'b111);
    req_in = '0;
    k = 0;
    while (req_out && k < 40) begin @(negedge clk); k++; end
    chk("req_out_manual_fall", req_out, 0);
    ack_out = 1'b0;
    k = 0;
    while (ack_in != '0 && k < 40) begin @(negedge clk); k++; end
    chk("ack_in_manual_rtz", ack_in, 0);
    @(negedge clk);

    auto_ack = 1'b1;
    for (int n = 0; n < 20; n++) begin
      logic [N-1:0] m;
      m = 3'($urandom_range(1, 7));
      do_hs(m, 1'($urandom));
    end
    chk("no_proto_random", proto_err, 0);
    chk("no_timeout_random", timeout_err, 0);

    // Reset during ACK aborts without counting
    auto_ack = 1'b0;
    en = 3'b011; push_exp(3'b011); req_in = 3'b011;
    k = 0;
    while (!req_out && k < 40) begin @(negedge clk); k++; end
    ack_out = 1'b1; @(negedge clk);
    chk("ack_in_pre_rst", ack_in, 3'b011);
    rst = 1'b1; @(negedge clk);
    exp_q.delete(); exp_cnt = '0;
    chk("rst2_q", q, 0); chk("rst2_req_out", req_out, 0); chk("rst2_ack_in", ack_in, 0);
    chk("rst2_count", hs_count, 0); chk("rst2_proto", proto_err, 0);
    req_in = '0; ack_out = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    auto_ack = 1'b1;
    do_hs(3'b010, 1'b0);
    do_hs(3'b111, 1'b1);
    repeat (4) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
